io_uart_tx: RTL and testbench



---
 rtl/io_uart_pkg.sv | 18 +
 rtl/io_sync_fifo.sv | 39 +++
 rtl/io_uart_tx.sv | 89 ++++++++
 tb/tb_io_uart_tx.sv | 135 +++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// io_uart_pkg: register map, status bit positions, serialiser states and reset divider
package io_uart_pkg;
  localparam int REG_TXDATA = 'h0;
  localparam int REG_STATUS = 'h4;
  localparam int REG_BAUDDIV = 'h8;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT = 8;
  localparam int DEFAULT_DIV = 868;
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;
endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, status and baud-divider registers
module io_uart_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DEFAULT_DIV = io_uart_pkg::DEFAULT_DIV,
  parameter int ADDR_BITS = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] IO_memAddr_i,
  input  logic [31:0] IO_memWData_i,
  input  logic        IO_memWr_i,
  output logic [31:0] IO_memRData_o,
  output logic        uart_tx_o
);
  import io_uart_pkg::*;
  logic [ADDR_BITS-1:0] off;
  logic wr_tx, wr_st, wr_bd, pop, full, empty, ovf, bit_end, unused;
  logic [7:0] fifo_dout, shift;
  logic [CW-1:0] count;
  logic [15:0] baud_div, div, baud_cnt;
  logic [2:0] bit_idx;
  tx_state_e state, state_nx;
  assign off = {IO_memAddr_i[ADDR_BITS-1:2], 2'b00};
  assign wr_tx = IO_memWr_i && off == ADDR_BITS'(REG_TXDATA);
  assign wr_st = IO_memWr_i && off == ADDR_BITS'(REG_STATUS);
  assign wr_bd = IO_memWr_i && off == ADDR_BITS'(REG_BAUDDIV);
  assign unused = ^{IO_memAddr_i[31:ADDR_BITS], IO_memAddr_i[1:0], IO_memWData_i[31:16]};
  assign div = baud_div == '0 ? 16'd1 : baud_div;
  // live compare so a shrinking divider ends the current bit on the next clock
  assign bit_end = baud_cnt >= div - 16'd1;
  assign pop = !empty && (state == IDLE || (state == STOP && bit_end));
  io_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .push(wr_tx),
    .pop(pop),
    .din(IO_memWData_i[7:0]),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = empty ? IDLE : START;
      START: state_nx = bit_end ? DATA : START;
      DATA: state_nx = bit_end && bit_idx == 3'd7 ? STOP : DATA;
      STOP: state_nx = !bit_end ? STOP : empty ? IDLE : START;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf <= 1'b0;
      baud_div <= 16'(DEFAULT_DIV);
      baud_cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else begin
      ovf <= (wr_tx && full && !pop) || (ovf && !(wr_st && IO_memWData_i[ST_OVF]));
      if (wr_bd) baud_div <= IO_memWData_i[15:0];
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 16'd1;
      bit_idx <= state == DATA ? bit_idx + 3'(bit_end) : '0;
      shift <= pop ? fifo_dout : (state == DATA && bit_end) ? shift >> 1 : shift;
    end
  end
  always_comb begin
    uart_tx_o = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    IO_memRData_o = '0;
    if (off == ADDR_BITS'(REG_STATUS)) begin
      IO_memRData_o[ST_BUSY] = state != IDLE;
      IO_memRData_o[ST_FULL] = full;
      IO_memRData_o[ST_EMPTY] = empty;
      IO_memRData_o[ST_OVF] = ovf;
      IO_memRData_o[ST_CNT +: 8] = 8'(count);
    end else if (off == ADDR_BITS'(REG_BAUDDIV)) begin
      IO_memRData_o[15:0] = baud_div;
    end
  end
endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed self-checking bench for io_uart_tx
module tb_io_uart_tx;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic we = 1'b0;
  logic [31:0] addr = 32'h4;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic tx;
  int checks = 0;
  int errors = 0;
  io_uart_tx dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .IO_memAddr_i(addr),
    .IO_memWData_i(wdata),
    .IO_memWr_i(we),
    .IO_memRData_o(rdata),
    .uart_tx_o(tx)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
    addr = 32'h4;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    tick;
    we = 1'b0;
    addr = 32'h4;
  endtask
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      tick;
      chk("line", 32'(tx), 32'(v));
      chk("busy", 32'(rdata[0]), 32'd1);
    end
  endtask
  task automatic frame(input logic [7:0] b, input int div);
    hold(1'b0, div);
    for (int i = 0; i < 8; i++) hold(b[i], div);
    hold(1'b1, div);
  endtask
  initial begin
    tick;
    tick;
    reset_i = 1'b0;
    chk("rst_line", 32'(tx), 32'd1);
    rd("rst_status", 32'h4, 32'h4);
    rd("rst_div", 32'h8, 32'd868);
    rd("rst_txdata_rd", 32'h0, 32'h0);
    rd("rst_reg_c", 32'hC, 32'h0);
    wr(32'h8, 32'd4);
    rd("div4", 32'h8, 32'd4);
    wr(32'h0, 32'hA5);
    frame(8'hA5, 4);
    tick;
    chk("a5_idle_line", 32'(tx), 32'd1);
    rd("a5_idle_status", 32'h4, 32'h4);
    wr(32'h8, 32'd2);
    for (int i = 0; i < 17; i++) wr(32'h0, 32'h10 + 32'(i));
    rd("full_status", 32'h4, 32'h1003);
    wr(32'h0, 32'hEE);
    rd("ovf_set", 32'h4, 32'h100B);
    wr(32'h4, 32'h8);
    rd("ovf_clr", 32'h4, 32'h1003);
    chk("f1_bit7", 32'(tx), 32'd0);
    hold(1'b1, 2);
    for (int i = 1; i < 17; i++) frame(8'(8'h10 + i), 2);
    tick;
    chk("burst_idle_line", 32'(tx), 32'd1);
    rd("burst_idle_status", 32'h4, 32'h4);
    wr(32'h8, 32'd0);
    rd("div0", 32'h8, 32'd0);
    wr(32'h0, 32'h00);
    frame(8'h00, 1);
    tick;
    chk("div0_idle_line", 32'(tx), 32'd1);
    rd("div0_idle_status", 32'h4, 32'h4);
    wr(32'h8, 32'd4);
    wr(32'h0, 32'h07);
    wr(32'h0, 32'h33);
    wr(32'h0, 32'h44);
    hold(1'b0, 2);
    hold(1'b1, 12);
    hold(1'b0, 2);
    reset_i = 1'b1;
    tick;
    reset_i = 1'b0;
    chk("midrst_line", 32'(tx), 32'd1);
    rd("midrst_status", 32'h4, 32'h4);
    rd("midrst_div", 32'h8, 32'd868);
    for (int i = 0; i < 60; i++) begin
      tick;
      chk("midrst_quiet", 32'(tx), 32'd1);
    end
    rd("midrst_end_status", 32'h4, 32'h4);
    wr(32'h8, 32'd4);
    wr(32'h0, 32'h5A);
    hold(1'b0, 4);
    hold(1'b0, 4);
    hold(1'b1, 4);
    hold(1'b0, 1);
    wr(32'h8, 32'd8);
    chk("bd_switch_line", 32'(tx), 32'd0);
    hold(1'b0, 6);
    hold(1'b1, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 8);
    tick;
    chk("bd_idle_line", 32'(tx), 32'd1);
    rd("bd_idle_status", 32'h4, 32'h4);
    rd("bd_div8", 32'h8, 32'd8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
